action_issuer: RTL
==================

Name: action_issuer

Overview:
- Front end of the fighting-game datapath. Turns raw button presses from two players into 3-bit action codes (action1, action2) and a framed actionEnable pulse for the player position/health FSMs.
- Each round: collect one debounced press per player, substitute await on timeout, then drive actionEnable high and back low so each player FSM executes exactly one action.
- Stops issuing rounds when isGameOver is raised.

Parameters:
- DEBOUNCE, default 4: consecutive synchronized high samples needed to accept a press (1..15).
- TIMEOUT, default 1000: maximum COLLECT length in cycles before unlocked players default to await (≥1).
- ENABLE_CYCLES, default 2: cycles actionEnable is held high per round (≥1).
- GAP_CYCLES, default 2: cycles actionEnable is held low after each enable, before collection resumes (≥1).
- RC_W, default 8: width of round_count.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- isGameOver  in  1  from health/referee logic; stops further rounds.
- btn1  in  8  player-1 raw buttons; bit index = action code (0 kick, 1 punch, 2 await, 3 jump, 4 left1, 5 left2, 6 right1, 7 right2).
- btn2  in  8  player-2 raw buttons, same encoding.
- action1  out  3  registered player-1 action code.
- action2  out  3  registered player-2 action code.
- actionEnable  out  1  registered action strobe to the player FSMs.
- p1_locked  out  1  player-1 action captured for the current round.
- p2_locked  out  1  player-2 action captured for the current round.
- round_count  out  RC_W  rounds issued; wraps modulo 2^RC_W.

Behaviour:
- Reset (sampled on clk edge):
  - state IDLE; action1 = action2 = 3'b010 (await); actionEnable = 0.
  - p1_locked = p2_locked = 0; round_count = 0.
  - Sync flops, debounce counters and timer cleared.
  - Reset asserted mid-round (any state) gives these values on the next edge; no partial round completes.
- Input conditioning, per button:
  - 2-flop synchronizer, then a saturating counter. The counter increments while the synced bit is 1 and clears to 0 when it is 0.
  - Debounced level goes high on the edge where the counter reaches DEBOUNCE, i.e. DEBOUNCE+2 edges after raw is first sampled high, with raw held high throughout.
  - Debounced level goes low on the first synced 0.
  - A press event is the debounced rising edge only. Holding a button produces one event. A pulse shorter than DEBOUNCE synced cycles produces none.
  - When several of a player's buttons produce events in the same cycle, the lowest bit index wins.
- FSM states: IDLE, COLLECT, ISSUE, GAP, OVER.
  - IDLE:
    - isGameOver=1 → OVER.
    - Otherwise → COLLECT; timer loaded with TIMEOUT-1; locks cleared.
  - COLLECT:
    - A press event for an unlocked player latches its code into that player's pending register and sets its lock. Events for a locked player are ignored.
    - isGameOver=1 → OVER. Actions and locks are left unchanged; no enable is issued.
    - Else, if both locks are set, counting presses accepted this cycle → ISSUE.
    - Else, if timer==0 → ISSUE. Any unlocked player's pending code is forced to 3'b010.
    - Else timer decrements.
    - A press arriving in the same cycle as timer==0 is accepted and wins over the await default.
  - Entry to ISSUE (single edge):
    - action1/action2 take the pending codes.
    - actionEnable goes to 1.
    - round_count increments.
  - ISSUE: actionEnable=1 for exactly ENABLE_CYCLES cycles, then → GAP.
  - GAP:
    - actionEnable=0 for exactly GAP_CYCLES cycles.
    - At the end: isGameOver=1 → OVER; else → COLLECT, with locks cleared and timer reloaded.
  - action1/action2 are stable throughout ISSUE and GAP and change only on COLLECT→ISSUE.
  - Presses during ISSUE/GAP are discarded, not queued. A button held across the round boundary does not re-trigger; it must be released and pressed again.
  - isGameOver rising during ISSUE/GAP does not truncate the round: the full enable and gap complete, then → OVER.
  - OVER: actionEnable=0, outputs frozen, exit only by reset.
- Arithmetic:
  - Timer width is clog2(TIMEOUT).
  - round_count wraps from 2^RC_W-1 to 0.
  - Debounce counter saturates at DEBOUNCE.

Test Plan:
1. Both players press (DEBOUNCE=4): after reset, raise btn1[6] and btn2[0] together, held. → Both locks set at edge 6. On the next edge action1=110, action2=000, actionEnable=1 for 2 cycles, then 0 for 2 cycles; round_count=1; locks clear on re-entry to COLLECT.
2. Timeout default (TIMEOUT=10): only btn1[1] pressed. → After 10 COLLECT cycles, action1=001, action2=010, actionEnable pulses; p2_locked stays 0 through the round.
3. Filtering: 2-cycle glitch on btn2[3] → no lock. Simultaneous btn1=8'b0001_0010 → action1=001.
4. Ignored presses: p1 presses kick then right1 within one COLLECT, and p2 presses during ISSUE. → action1=000; p2's ISSUE press is not used next round; p2 must release and re-press to lock.
5. Game over: isGameOver raised in the second ISSUE cycle. → Enable and gap finish, state OVER, actionEnable stays 0 for ≥50 cycles despite presses. Reset → IDLE, action codes 010, round_count 0.
6. Reset mid-ISSUE, and round_count wrap with RC_W=2 after 4 rounds. → Reset gives actionEnable=0 and actions 010 on the next edge; round_count reads 0 after the 4th issue.

Source files
------------

// File: rtl/action_issuer.sv
// rtl/action_issuer.sv - two-player button conditioning and action round sequencer
// Each round locks one debounced press per player, then frames it with actionEnable and a quiet gap.
module action_issuer #(
  parameter int DEBOUNCE      = 4,
  parameter int TIMEOUT       = 1000,
  parameter int ENABLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int RC_W          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            isGameOver,
  input  logic [7:0]      btn1,
  input  logic [7:0]      btn2,
  output logic [2:0]      action1,
  output logic [2:0]      action2,
  output logic            actionEnable,
  output logic            p1_locked,
  output logic            p2_locked,
  output logic [RC_W-1:0] round_count
);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PMAX = (ENABLE_CYCLES > GAP_CYCLES) ? ENABLE_CYCLES : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] E_LAST  = PW'(ENABLE_CYCLES);
  localparam logic [PW-1:0] G_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [3:0]    DB_FULL = 4'(DEBOUNCE);
  localparam logic [3:0]    DB_EDGE = 4'(DEBOUNCE - 1);
  localparam logic [2:0]    AWAIT   = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_GAP, S_OVER} state_t;

  logic [15:0] meta;
  logic [15:0] synced;
  logic [15:0] press;
  logic [3:0]  db_cnt [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= '0;
      synced <= '0;
      for (int i = 0; i < 16; i++) db_cnt[i] <= '0;
    end else begin
      meta   <= {btn2, btn1};
      synced <= meta;
      for (int i = 0; i < 16; i++) begin
        if (!synced[i])                db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_FULL) db_cnt[i] <= db_cnt[i] + 4'd1;
      end
    end
  end

  // A press is the edge on which the counter reaches DEBOUNCE; saturation keeps a held button silent.
  always_comb begin
    press = '0;
    for (int i = 0; i < 16; i++) press[i] = synced[i] && (db_cnt[i] == DB_EDGE);
  end

  function automatic logic [3:0] pick_lowest(input logic [7:0] ev);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (ev[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] ev1;
  logic [3:0] ev2;
  assign ev1 = pick_lowest(press[7:0]);
  assign ev2 = pick_lowest(press[15:8]);

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [PW-1:0]   phase, phase_next;
  logic [2:0]      pend1, pend1_next, pend2, pend2_next;
  logic [2:0]      act1_next, act2_next;
  logic            lock1_next, lock2_next, en_next;
  logic [RC_W-1:0] rc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      phase        <= '0;
      pend1        <= AWAIT;
      pend2        <= AWAIT;
      p1_locked    <= 1'b0;
      p2_locked    <= 1'b0;
      action1      <= AWAIT;
      action2      <= AWAIT;
      actionEnable <= 1'b0;
      round_count  <= '0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      phase        <= phase_next;
      pend1        <= pend1_next;
      pend2        <= pend2_next;
      p1_locked    <= lock1_next;
      p2_locked    <= lock2_next;
      action1      <= act1_next;
      action2      <= act2_next;
      actionEnable <= en_next;
      round_count  <= rc_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    phase_next = phase;
    pend1_next = pend1;
    pend2_next = pend2;
    lock1_next = p1_locked;
    lock2_next = p2_locked;
    act1_next  = action1;
    act2_next  = action2;
    en_next    = 1'b0;
    rc_next    = round_count;
    case (state)
      S_IDLE: begin
        if (isGameOver) begin
          state_next = S_OVER;
        end else begin
          state_next = S_COLLECT;
          timer_next = T_LOAD;
          lock1_next = 1'b0;
          lock2_next = 1'b0;
        end
      end
      S_COLLECT: begin
        if (isGameOver) begin
          state_next = S_OVER;
        end else begin
          if (ev1[3] && !p1_locked) begin
            pend1_next = ev1[2:0];
            lock1_next = 1'b1;
          end
          if (ev2[3] && !p2_locked) begin
            pend2_next = ev2[2:0];
            lock2_next = 1'b1;
          end
          if (lock1_next && lock2_next) begin
            state_next = S_ISSUE;
            phase_next = '0;
          end else if (timer == '0) begin
            state_next = S_ISSUE;
            phase_next = '0;
            if (!lock1_next) pend1_next = AWAIT;
            if (!lock2_next) pend2_next = AWAIT;
          end else begin
            timer_next = timer - 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // Phase 0 lets the pending registers settle; the codes and enable appear on its closing edge.
        if (phase == '0) begin
          act1_next = pend1;
          act2_next = pend2;
          rc_next   = round_count + 1'b1;
        end
        if (phase == E_LAST) begin
          state_next = S_GAP;
          phase_next = '0;
        end else begin
          en_next    = 1'b1;
          phase_next = phase + 1'b1;
        end
      end
      S_GAP: begin
        if (phase == G_LAST) begin
          if (isGameOver) begin
            state_next = S_OVER;
          end else begin
            state_next = S_COLLECT;
            timer_next = T_LOAD;
            lock1_next = 1'b0;
            lock2_next = 1'b0;
          end
        end else begin
          phase_next = phase + 1'b1;
        end
      end
      S_OVER: begin
        state_next = S_OVER;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end
endmodule
